// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front-end.
//
// This block owns the program counter. It issues word-aligned fetch requests to
// instruction memory, buffers the in-order responses in a small FIFO, and presents
// each buffered instruction, together with its PC, to decode.
//
// A request is issued only when the FIFO has room for its response. This credit
// rule is what allows imem_rsp_valid to be accepted without back-pressure.
//
// A redirect flushes the FIFO and reloads the PC. Every response still in flight
// at that moment is counted as stale and dropped when it arrives.
//
// Optional feature, selected by the macro INST_FETCH_BYPASS_EN:
//   - Defined: when the FIFO is empty, a kept response goes straight to decode in
//     the same cycle.
//   - Undefined: every response passes through the FIFO, adding one cycle.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   imem_req_*           fetch request handshake (valid/ready) with byte address
//   imem_rsp_*           in-order response beat with instruction data
//   redirect_valid/pc    single-cycle flush and PC load (pc[1:0] ignored)
//   inst_valid/data/pc   head instruction to decode
//   inst_ready           decode consumes the head entry
module inst_fetch_queue #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             inst_valid,
  output logic [INS_W-1:0] inst_data,
  output logic [PC_W-1:0]  inst_pc,
  input  logic             inst_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  cnt_t             outstanding_q, outstanding_d;
  cnt_t             discard_q, discard_d;
  logic             running_q, running_d;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [INS_W-1:0] data_mem [DEPTH];

  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_keep;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [CntW:0]    credit_sum;
  logic [PC_W-1:0]  redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~PC_W'(3);
  assign fifo_empty          = (count_q == '0);

  // The slots promised to in-flight requests count against the FIFO capacity.
  assign credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = running_q && (credit_sum < (CntW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A beat with nothing outstanding is a protocol violation. It is ignored.
  assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep = rsp_fire && (discard_q == '0);

`ifdef INST_FETCH_BYPASS_EN
  logic bypass;
  assign bypass = rsp_keep && fifo_empty && !redirect_valid;

  always_comb begin
    inst_valid = !fifo_empty || bypass;
    inst_data  = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst_data = data_mem[rd_ptr_q];
      inst_pc   = pc_mem[rd_ptr_q];
    end else if (bypass) begin
      inst_data = imem_rsp_data;
      inst_pc   = rsp_pc_q;
    end
  end

  // A bypassed beat that decode takes immediately never occupies a slot.
  assign push = rsp_keep && !(bypass && inst_ready);
  assign pop  = !fifo_empty && inst_ready;
`else
  // Outputs are forced to zero while empty, so reset shows zero data and PC.
  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign inst_pc    = fifo_empty ? '0 : pc_mem[rd_ptr_q];
  assign push       = rsp_keep;
  assign pop        = !fifo_empty && inst_ready;
`endif

  always_comb begin
    running_d     = 1'b1;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
    fetch_pc_d    = req_fire ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
    rsp_pc_d      = rsp_keep ? rsp_pc_q + PC_W'(4) : rsp_pc_q;
    discard_d     = (rsp_fire && (discard_q != '0)) ? discard_q - cnt_t'(1) : discard_q;
    count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    wr_ptr_d      = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      discard_d  = outstanding_d;
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      running_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      running_q     <= running_d;
    end
  end

  // Payload storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      data_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build, PC_W=8, DEPTH=4).
// A small in-order memory model returns responses one cycle after each request.
// Its response data is 32'hC0DE_00xx, where xx is the request address.
module tb_inst_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [7:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  logic hold = 1'b0;
  logic [7:0] pend[$];

  inst_fetch_queue #(
    .PC_W    (8),
    .INS_W   (32),
    .DEPTH   (4),
    .RESET_PC(8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    imem_rsp_valid = !hold && (pend.size() > 0);
    imem_rsp_data  = (pend.size() > 0) ? {24'hC0DE00, pend[0]} : 32'h0;
  endtask

  // One clock: sample the request handshake mid-cycle, then update the memory model.
  task automatic tick();
    logic       f;
    logic [7:0] a;
    @(negedge clk);
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
    if (f) begin
      pend.push_back(a);
      fire_cnt++;
    end
    drive_rsp();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    hold           = 1'b0;
    pend.delete();
    drive_rsp();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    fire_cnt = 0;
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    inst_ready     = 1'b1;
    #12;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_pc", inst_pc, 8'h00);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_req_addr", imem_req_addr, 8'h00);

    // Streaming with latency-1 memory.
    do_reset();
    inst_ready = 1'b1;
    tick();
    check("s_req_valid", imem_req_valid, 1'b1);
    check("s_addr0", imem_req_addr, 8'h00);
    tick();
    check("s_addr4", imem_req_addr, 8'h04);
    check("s_inst_valid_early", inst_valid, 1'b0);
    tick();
    check("s_inst_valid", inst_valid, 1'b1);
    check("s_pc0", inst_pc, 8'h00);
    check("s_data0", inst_data, 32'hC0DE0000);
    check("s_addr8", imem_req_addr, 8'h08);
    tick();
    check("s_pc4", inst_pc, 8'h04);
    check("s_addrc", imem_req_addr, 8'h0C);
    tick();
    check("s_pc8", inst_pc, 8'h08);
    check("s_data8", inst_data, 32'hC0DE0008);

    // Back-pressure: four requests fill the credit, then fetching stops.
    do_reset();
    inst_ready = 1'b0;
    repeat (6) tick();
    check("bp_req_valid_low", imem_req_valid, 1'b0);
    check("bp_head_pc", inst_pc, 8'h00);
    tick();
    check("bp_fire_cnt", fire_cnt, 4);
    check("bp_still_low", imem_req_valid, 1'b0);
    inst_ready = 1'b1;
    tick();
    check("bp_pc4", inst_pc, 8'h04);
    check("bp_resume", imem_req_valid, 1'b1);
    check("bp_resume_addr", imem_req_addr, 8'h10);
    tick();
    check("bp_pc8", inst_pc, 8'h08);
    check("bp_fire_cnt2", fire_cnt, 5);
    tick();
    check("bp_pcc", inst_pc, 8'h0C);
    tick();
    check("bp_pc10", inst_pc, 8'h10);

    // Redirect to 0x43 with two responses held outstanding.
    do_reset();
    inst_ready = 1'b1;
    hold       = 1'b1;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h43;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    hold           = 1'b0;
    drive_rsp();
    check("rd_addr40", imem_req_addr, 8'h40);
    check("rd_req_valid", imem_req_valid, 1'b1);
    check("rd_inst_valid0", inst_valid, 1'b0);
    tick();
    check("rd_drop1", inst_valid, 1'b0);
    tick();
    check("rd_drop2", inst_valid, 1'b0);
    tick();
    check("rd_first_valid", inst_valid, 1'b1);
    check("rd_first_pc", inst_pc, 8'h40);
    check("rd_first_data", inst_data, 32'hC0DE0040);
    tick();
    check("rd_second_pc", inst_pc, 8'h44);

    // Redirect in the same cycle as a request fire and a response beat.
    do_reset();
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    check("rf_inst_valid_after", inst_valid, 1'b0);
    check("rf_addr80", imem_req_addr, 8'h80);
    tick();
    check("rf_stale_dropped", inst_valid, 1'b0);
    tick();
    check("rf_first_pc", inst_pc, 8'h80);
    check("rf_first_valid", inst_valid, 1'b1);
    tick();
    check("rf_second_pc", inst_pc, 8'h84);

    // PC wrap from 0xFC to 0x00.
    do_reset();
    inst_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    check("wr_addrf8", imem_req_addr, 8'hF8);
    tick();
    check("wr_addrfc", imem_req_addr, 8'hFC);
    tick();
    check("wr_addr00", imem_req_addr, 8'h00);
    check("wr_pcf8", inst_pc, 8'hF8);
    tick();
    check("wr_pcfc", inst_pc, 8'hFC);
    tick();
    check("wr_pc00", inst_pc, 8'h00);
    check("wr_data00", inst_data, 32'hC0DE0000);

    // A beat with nothing outstanding must be ignored.
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    tick();
    check("pv_no_push", inst_valid, 1'b0);
    check("pv_req_valid", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    tick();
    tick();
    check("pv_pc0", inst_pc, 8'h00);
    check("pv_data0", inst_data, 32'hC0DE0000);

    // Asynchronous reset with a full FIFO.
    do_reset();
    inst_ready = 1'b0;
    repeat (6) tick();
    check("ar_full_valid", inst_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_inst_valid", inst_valid, 1'b0);
    check("ar_req_valid", imem_req_valid, 1'b0);
    check("ar_inst_pc", inst_pc, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    drive_rsp();
    inst_ready = 1'b1;
    tick();
    check("ar_restart_valid", imem_req_valid, 1'b1);
    check("ar_restart_addr", imem_req_addr, 8'h00);
    tick();
    tick();
    check("ar_first_pc", inst_pc, 8'h00);
    check("ar_first_valid", inst_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
